// File: rtl/pipeline_stall_ctrl.sv
// Stall/bubble/flush sequencer for the 5-stage pipe: load-use bubbles, mul/div freeze, branch flush.
// Define STALL_PERF_CNT_EN to add the perf_lu_stalls / perf_md_stalls saturating counters.
module pipeline_stall_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_raddr1,
    input  logic [4:0] id_raddr2,
    input  logic       id_re1,
    input  logic       id_re2,
    input  logic       id_branch_taken,
    input  logic [4:0] ex_waddr,
    input  logic       ex_reg_wr,
    input  logic       ex_mem_read,
    input  logic       ex_md_op,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       stall_id_ex,
    output logic       bubble_id_ex,
    output logic       flush_if_id,
    output logic       md_busy,
    output logic       md_done
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_md_stalls
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;
    localparam logic [1:0] MD_LAST = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic idle, md_start, md_freeze, md_last, lu_raw, lu_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The IDLE cycle that accepts the op is the first busy cycle, so the counter
    // holds the cycles still to go; MD_LAST is entered as it reaches 1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (ex_md_op) begin
                    cnt_next   = CNT_LOAD;
                    state_next = (CNT_LOAD == CNT_ONE) ? MD_LAST : MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_next == CNT_ONE) begin
                    state_next = MD_LAST;
                end
            end
            MD_LAST: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign idle      = (state_reg == IDLE);
    assign md_start  = idle & ex_md_op;
    assign md_freeze = md_start | (state_reg == MD_BUSY);
    assign md_last   = (state_reg == MD_LAST);

    assign lu_raw = ex_mem_read & ex_reg_wr & (ex_waddr != 5'd0)
                  & ((id_re1 & (id_raddr1 == ex_waddr)) | (id_re2 & (id_raddr2 == ex_waddr)));
    assign lu_stall = idle & ~ex_md_op & lu_raw;

    // Outputs are forced low for as long as reset is held, independent of inputs.
    assign stall_pc     = ~rst & (md_freeze | lu_stall);
    assign stall_if_id  = ~rst & (md_freeze | lu_stall);
    assign stall_id_ex  = ~rst & md_freeze;
    assign bubble_id_ex = ~rst & lu_stall;
    assign flush_if_id  = ~rst & id_branch_taken & ~(md_freeze | lu_stall);
    assign md_busy      = ~rst & (md_freeze | md_last);
    assign md_done      = ~rst & md_last;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_lu_reg, perf_md_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_reg <= '0;
            perf_md_reg <= '0;
        end else begin
            if (idle && lu_raw && (perf_lu_reg != 32'hFFFF_FFFF)) begin
                perf_lu_reg <= perf_lu_reg + 32'd1;
            end
            if (md_freeze && (perf_md_reg != 32'hFFFF_FFFF)) begin
                perf_md_reg <= perf_md_reg + 32'd1;
            end
        end
    end

    assign perf_lu_stalls = perf_lu_reg;
    assign perf_md_stalls = perf_md_reg;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized scoreboard bench for pipeline_stall_ctrl: driver pushes expected outputs, monitor compares.
module tb_pipeline_stall_ctrl;

    localparam int MD_LATENCY = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_raddr1, id_raddr2, ex_waddr;
    logic       id_re1, id_re2, id_branch_taken, ex_reg_wr, ex_mem_read, ex_md_op;
    logic       stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, md_busy, md_done;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_md_stalls;
`endif

    pipeline_stall_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_raddr1       (id_raddr1),
        .id_raddr2       (id_raddr2),
        .id_re1          (id_re1),
        .id_re2          (id_re2),
        .id_branch_taken (id_branch_taken),
        .ex_waddr        (ex_waddr),
        .ex_reg_wr       (ex_reg_wr),
        .ex_mem_read     (ex_mem_read),
        .ex_md_op        (ex_md_op),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .md_busy         (md_busy),
        .md_done         (md_done)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_lu_stalls  (perf_lu_stalls),
        .perf_md_stalls  (perf_md_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] outs;  // {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, md_busy, md_done}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: number of mul/div cycles still owed after the accepting cycle.
    int   md_left = 0;

    task automatic step(input string tag, input logic r,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic re1, input logic re2, input logic br,
                        input logic [4:0] wa, input logic wr, input logic mr, input logic md);
        exp_t e;
        logic s_pc, s_ifid, s_idex, bub, fl, busy, done, lu;
        @(posedge clk);
        #1;
        rst = r; id_raddr1 = ra1; id_raddr2 = ra2; id_re1 = re1; id_re2 = re2;
        id_branch_taken = br; ex_waddr = wa; ex_reg_wr = wr; ex_mem_read = mr; ex_md_op = md;

        s_pc = 0; s_ifid = 0; s_idex = 0; bub = 0; fl = 0; busy = 0; done = 0;
        if (!r) begin
            lu = mr && wr && (wa != 0) && ((re1 && ra1 == wa) || (re2 && ra2 == wa));
            if (md_left == 1) begin
                busy = 1; done = 1;
            end else if (md_left > 1 || md) begin
                s_pc = 1; s_ifid = 1; s_idex = 1; busy = 1;
            end else if (lu) begin
                s_pc = 1; s_ifid = 1; bub = 1;
            end
            fl = br && !s_ifid;
        end
        e.tag  = tag;
        e.outs = {s_pc, s_ifid, s_idex, bub, fl, busy, done};
        exp_q.push_back(e);

        if (r)               md_left = 0;
        else if (md_left > 0) md_left = md_left - 1;
        else if (md)          md_left = MD_LATENCY - 1;
    endtask

    task automatic idle_step(input string tag, input logic br);
        step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, br, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: each cycle the DUT presents outputs, compare against the oldest expectation.
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, md_busy, md_done};
                checks++;
                txn++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL %s txn=%0d outs got=%b exp=%b", e.tag, txn, got, e.outs);
                end else begin
                    $display("txn %0d %s outs=%b", txn, e.tag, got);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; id_raddr1 = 0; id_raddr2 = 0; id_re1 = 0; id_re2 = 0; id_branch_taken = 0;
        ex_waddr = 0; ex_reg_wr = 0; ex_mem_read = 0; ex_md_op = 0;

        // Reset with hazardous inputs applied: outputs must stay low.
        step("reset", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        step("reset", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        idle_step("idle", 1'b0);

        // Load-use via re1, then clear.
        step("lu_r5", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        idle_step("lu_after", 1'b0);
        // Register 0 and non-reading sources never stall.
        step("lu_r0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step("lu_nore", 1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step("lu_re2", 1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);

        // Mul/div pulse: 7 frozen cycles, done on the 8th.
        step("md_start", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MD_LATENCY; i++) idle_step("md_run", 1'b0);

        // Branch held under a load-use stall flushes the cycle the stall releases.
        step("br_lu", 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
        idle_step("br_rel", 1'b1);

        // Reset three cycles into the mul/div freeze; no md_done afterwards.
        step("md_start", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle_step("md_run", 1'b0);
        step("md_rst", 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) idle_step("post_rst", 1'b0);

        // Randomized traffic over a small register range so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0));
        end
        idle_step("tail", 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
